// File: rtl/qacc_accum.sv
// qacc_accum: sign-magnitude product accumulator with per-vector sticky overflow.
// Optional build macro QACC_SAT_EN saturates the result magnitude on overflow.
`default_nettype none

module qacc_accum #(
  parameter int Q       = 15,
  parameter int N       = 32,
  parameter int GUARD   = 8,
  parameter int MAX_LEN = 256
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic [N-1:0]                 i_data,
  input  logic                         i_ovr,
  input  logic                         i_last,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [N-1:0]                 o_sum,
  output logic                         o_ovr,
  output logic [$clog2(MAX_LEN):0]     o_count
);

  localparam int c_AW = N + GUARD;
  localparam int c_CW = $clog2(MAX_LEN) + 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACC = 2'd1, S_DONE = 2'd2} state_t;

  state_t            r_state;
  logic [c_AW-1:0]   r_acc;
  logic [c_CW-1:0]   r_count;
  logic              r_ovr;

  logic [N-2:0]      w_mag;
  logic [c_AW-1:0]   w_mag_ext;
  logic [c_AW-1:0]   w_beat;
  logic              w_take;
  logic              w_first;
  logic [c_AW-1:0]   w_acc_nxt;
  logic [c_CW-1:0]   w_cnt_nxt;
  logic              w_ovr_nxt;
  logic              w_final;
  logic              w_neg;
  logic [c_AW-1:0]   w_abs;
  logic              w_big;
  logic [N-2:0]      w_res_mag;
  logic              w_unused_q;

  // Q only fixes the interpretation of the format; the arithmetic is scale-free.
  assign w_unused_q = (Q < N);

  assign w_mag     = i_data[N-2:0];
  assign w_mag_ext = {{(c_AW-N+1){1'b0}}, w_mag};
  assign w_beat    = (i_data[N-1] && (|w_mag)) ? (~w_mag_ext + 1'b1) : w_mag_ext;

  assign o_ready   = (r_state != S_DONE);
  assign o_valid   = (r_state == S_DONE);
  assign w_take    = i_valid && o_ready;
  assign w_first   = (r_state == S_IDLE);

  assign w_acc_nxt = w_first ? w_beat : (r_acc + w_beat);
  assign w_cnt_nxt = w_first ? c_CW'(1) : (r_count + c_CW'(1));
  assign w_ovr_nxt = w_first ? i_ovr : (r_ovr | i_ovr);
  assign w_final   = i_last || (w_cnt_nxt == c_CW'(MAX_LEN));

  assign w_neg     = w_acc_nxt[c_AW-1];
  assign w_abs     = w_neg ? (~w_acc_nxt + 1'b1) : w_acc_nxt;
  // Anything above the N-1 magnitude bits means the result does not fit.
  assign w_big     = |w_abs[c_AW-1:N-1];

`ifdef QACC_SAT_EN
  assign w_res_mag = w_big ? {(N-1){1'b1}} : w_abs[N-2:0];
`else
  assign w_res_mag = w_abs[N-2:0];
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_count <= '0;
      r_ovr   <= 1'b0;
      o_sum   <= '0;
      o_ovr   <= 1'b0;
      o_count <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_ACC: begin
          if (w_take) begin
            r_acc   <= w_acc_nxt;
            r_count <= w_cnt_nxt;
            r_ovr   <= w_ovr_nxt;
            if (w_final) begin
              r_state <= S_DONE;
              o_sum   <= {w_neg, w_res_mag};
              o_ovr   <= w_ovr_nxt | w_big;
              o_count <= w_cnt_nxt;
            end else begin
              r_state <= S_ACC;
            end
          end
        end
        S_DONE: begin
          if (i_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_qacc_accum.sv
// Self-checking bench for qacc_accum: directed cases plus random vectors vs. an arithmetic model.
`default_nettype none

module tb_qacc_accum;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [31:0] i_data = '0;
  logic        i_ovr = 1'b0;
  logic        i_last = 1'b0;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [31:0] o_sum;
  logic        o_ovr;
  logic [8:0]  o_count;

  int total = 0;
  int bad   = 0;

  logic [31:0] q_data[$];
  bit          q_ovr[$];

  qacc_accum #(.Q(15), .N(32), .GUARD(8), .MAX_LEN(256)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_data(i_data), .i_ovr(i_ovr), .i_last(i_last), .o_valid(o_valid),
    .i_ready(i_ready), .o_sum(o_sum), .o_ovr(o_ovr), .o_count(o_count)
  );

  always #5 i_clk = ~i_clk;

  // Reference: signed integer sum of the beats, then sign-magnitude with overflow rule.
  function automatic void model(output logic [31:0] s, output logic o, output logic [8:0] c);
    longint acc;
    longint a;
    logic   ov;
    logic [30:0] m;
    acc = 0;
    ov  = 1'b0;
    foreach (q_data[i]) begin
      longint v;
      v = longint'(q_data[i][30:0]);
      acc = q_data[i][31] ? acc - v : acc + v;
      ov  = ov | q_ovr[i];
    end
    a = (acc < 0) ? -acc : acc;
    m = a[30:0];
    if (a > 64'sd2147483647) begin
      ov = 1'b1;
`ifdef QACC_SAT_EN
      m = '1;
`endif
    end
    s = {(acc < 0), m};
    o = ov;
    c = 9'(q_data.size());
  endfunction

  // Drives the queued beats and waits (bounded) for o_valid; leaves the result held.
  task automatic run_vec(input bit use_last, input bit gaps,
                         output logic [31:0] s, output logic o, output logic [8:0] c, output bit got);
    i_ready = 1'b0;
    foreach (q_data[i]) begin
      if (gaps) begin
        int g;
        g = $urandom_range(0, 2);
        for (int k = 0; k < g; k++) begin
          i_valid = 1'b0;
          @(posedge i_clk); #1;
        end
      end
      i_valid = 1'b1;
      i_data  = q_data[i];
      i_ovr   = q_ovr[i];
      i_last  = use_last && (i == q_data.size() - 1);
      @(posedge i_clk); #1;
    end
    i_valid = 1'b0;
    i_last  = 1'b0;
    i_ovr   = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (o_valid) begin
        got = 1'b1;
        break;
      end
      @(posedge i_clk); #1;
    end
    s = o_sum;
    o = o_ovr;
    c = o_count;
  endtask

  task automatic release_result(input string tag);
    i_ready = 1'b1;
    @(posedge i_clk); #1;
    i_ready = 1'b0;
    total++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s release: valid=%b ready=%b required valid=0 ready=1", tag, o_valid, o_ready);
    end
  endtask

  task automatic test_reset;
    i_rst_n = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    total++;
    if ({o_valid, o_ready, o_sum, o_ovr, o_count} !== {1'b0, 1'b1, 32'h0, 1'b0, 9'h0}) begin
      bad++;
      $display("FAIL reset: valid=%b ready=%b sum=%h ovr=%b count=%0d required 0 1 0 0 0",
               o_valid, o_ready, o_sum, o_ovr, o_count);
    end
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
  endtask

  task automatic directed(input string tag, input logic [31:0] es, input logic eo, input logic [8:0] ec);
    logic [31:0] s; logic o; logic [8:0] c; bit got;
    run_vec(1'b1, 1'b0, s, o, c, got);
    total++;
    if (!got || s !== es || o !== eo || c !== ec) begin
      bad++;
      $display("FAIL %s: got=%b sum=%h ovr=%b count=%0d required sum=%h ovr=%b count=%0d",
               tag, got, s, o, c, es, eo, ec);
    end
    release_result(tag);
  endtask

  task automatic test_directed;
    q_data = '{32'h00008000}; q_ovr = '{0};
    directed("single", 32'h00008000, 1'b0, 9'd1);
    q_data = '{32'h00008000, 32'h00010000, 32'h80004000}; q_ovr = '{0, 0, 0};
    directed("three", 32'h00014000, 1'b0, 9'd3);
    q_data = '{32'h00004000, 32'h80004000}; q_ovr = '{0, 0};
    directed("cancel", 32'h00000000, 1'b0, 9'd2);
    q_data = '{32'h80000000}; q_ovr = '{0};
    directed("negzero", 32'h00000000, 1'b0, 9'd1);
    q_data = '{32'h7FFFFFFF, 32'h7FFFFFFF}; q_ovr = '{0, 0};
`ifdef QACC_SAT_EN
    directed("overflow", 32'h7FFFFFFF, 1'b1, 9'd2);
`else
    directed("overflow", 32'h7FFFFFFE, 1'b1, 9'd2);
`endif
    q_data = '{32'h00001000, 32'h00002000, 32'h00003000}; q_ovr = '{0, 1, 0};
    directed("in_ovr", 32'h00006000, 1'b1, 9'd3);
  endtask

  task automatic test_stall;
    logic [31:0] s; logic o; logic [8:0] c; bit got;
    q_data = '{32'h00010000, 32'h80002000}; q_ovr = '{0, 0};
    run_vec(1'b1, 1'b0, s, o, c, got);
    for (int k = 0; k < 5; k++) begin
      i_valid = 1'b1;
      i_data  = 32'h00010000;
      i_last  = 1'b1;
      @(posedge i_clk); #1;
      total++;
      if (o_ready !== 1'b0 || o_valid !== 1'b1 || o_sum !== 32'h0000E000 || o_count !== 9'd2 || o_ovr !== 1'b0) begin
        bad++;
        $display("FAIL stall%0d: ready=%b valid=%b sum=%h count=%0d ovr=%b required 0 1 0000e000 2 0",
                 k, o_ready, o_valid, o_sum, o_count, o_ovr);
      end
    end
    i_valid = 1'b0;
    i_last  = 1'b0;
    release_result("stall");
    q_data = '{32'h00000100}; q_ovr = '{0};
    directed("after_stall", 32'h00000100, 1'b0, 9'd1);
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 2; i++) begin
      i_valid = 1'b1;
      i_data  = 32'h00020000;
      i_last  = 1'b0;
      @(posedge i_clk); #1;
    end
    i_rst_n = 1'b0;
    #3;
    total++;
    if ({o_valid, o_ready, o_sum, o_ovr, o_count} !== {1'b0, 1'b1, 32'h0, 1'b0, 9'h0}) begin
      bad++;
      $display("FAIL reset_mid: valid=%b ready=%b sum=%h ovr=%b count=%0d required 0 1 0 0 0",
               o_valid, o_ready, o_sum, o_ovr, o_count);
    end
    i_valid = 1'b0;
    #2;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    q_data = '{32'h00008000}; q_ovr = '{0};
    directed("fresh", 32'h00008000, 1'b0, 9'd1);
  endtask

  task automatic test_maxlen;
    logic [31:0] s, es; logic o, eo; logic [8:0] c, ec; bit got;
    q_data = {}; q_ovr = {};
    for (int i = 0; i < 256; i++) begin
      q_data.push_back({1'($urandom_range(0, 1)), 31'($urandom_range(0, 32'h0001FFFF))});
      q_ovr.push_back(1'b0);
    end
    model(es, eo, ec);
    run_vec(1'b0, 1'b0, s, o, c, got);
    total++;
    if (!got || s !== es || o !== eo || c !== 9'd256) begin
      bad++;
      $display("FAIL maxlen: got=%b sum=%h ovr=%b count=%0d required sum=%h ovr=%b count=256",
               got, s, o, c, es, eo);
    end
    release_result("maxlen");
  endtask

  task automatic test_random;
    logic [31:0] s, es; logic o, eo; logic [8:0] c, ec; bit got;
    for (int t = 0; t < 30; t++) begin
      int len;
      len = $urandom_range(1, 8);
      q_data = {}; q_ovr = {};
      for (int i = 0; i < len; i++) begin
        logic [30:0] m;
        case ($urandom_range(0, 5))
          0:       m = 31'($urandom);
          1:       m = 31'h0;
          default: m = 31'($urandom_range(0, 32'h0003FFFF));
        endcase
        q_data.push_back({1'($urandom_range(0, 1)), m});
        q_ovr.push_back($urandom_range(0, 7) == 0);
      end
      model(es, eo, ec);
      run_vec(1'b1, 1'b1, s, o, c, got);
      total++;
      if (!got || s !== es || o !== eo || c !== ec) begin
        bad++;
        $display("FAIL random%0d: got=%b sum=%h ovr=%b count=%0d required sum=%h ovr=%b count=%0d",
                 t, got, s, o, c, es, eo, ec);
      end
      repeat ($urandom_range(0, 3)) @(posedge i_clk);
      #1;
      release_result("random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_reset_mid();
    test_maxlen();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/qacc_accum.md
QACC_ACCUM -- requirements
Module: qacc_accum

Interface
REQ-001 SHALL have parameter Q, default 15, number of fractional bits of the sign-magnitude operand format.
REQ-002 SHALL have parameter N, default 32, total word width: bit N-1 is the sign, bits N-2:0 are the magnitude.
REQ-003 SHALL have parameter GUARD, default 8, number of extra accumulator bits above N.
REQ-004 SHALL have parameter MAX_LEN, default 256, maximum number of beats per vector.
REQ-005 SHALL use one clock and an asynchronous active-low reset, as listed below.
REQ-006 SHALL have port i_clk, input, 1 bit, rising-edge clock.
REQ-007 SHALL have port i_rst_n, input, 1 bit, asynchronous active-low reset.
REQ-008 SHALL have port i_valid, input, 1 bit, upstream product beat valid.
REQ-009 SHALL have port o_ready, output, 1 bit, block can accept a beat.
REQ-010 SHALL have port i_data, input, N bits, sign-magnitude product from the multiplier stage.
REQ-011 SHALL have port i_ovr, input, 1 bit, overflow flag of that product.
REQ-012 SHALL have port i_last, input, 1 bit, final beat of the vector.
REQ-013 SHALL have port o_valid, output, 1 bit, accumulated result valid.
REQ-014 SHALL have port i_ready, input, 1 bit, downstream accepts the result.
REQ-015 SHALL have port o_sum, output, N bits, sign-magnitude sum.
REQ-016 SHALL have port o_ovr, output, 1 bit, sticky overflow for the vector.
REQ-017 SHALL have port o_count, output, clog2(MAX_LEN)+1 bits, number of beats accumulated.

Function
REQ-018 SHALL implement the states IDLE, ACC and DONE.
REQ-019 SHALL accept a beat only on a cycle where i_valid and o_ready are both 1, with o_ready = 1 in IDLE and ACC and o_ready = 0 in DONE.
REQ-020 SHALL convert each beat to a two's-complement value of N+GUARD bits: the magnitude is zero-extended, then negated when the sign is 1 and the magnitude is non-zero; negative zero is treated as zero.
REQ-021 SHALL, on a beat accepted in IDLE, load acc with the beat, set count to 1 and set ovr to i_ovr.
REQ-022 SHALL, on a beat accepted in ACC, set acc to acc + beat, increment count and OR i_ovr into ovr.
REQ-023 SHALL treat an accepted beat as final when i_last = 1 or the new count equals MAX_LEN; a final beat moves the state to DONE, otherwise the state is ACC.
REQ-024 SHALL register o_sum, o_ovr and o_count on the final-beat edge, and assert o_valid on the following cycle (latency 1 cycle from the final beat).
REQ-025 SHALL form o_sum from the sign of acc and |acc|; a zero result SHALL have sign 0.
REQ-026 SHALL flag overflow when |acc| > 2^(N-1)-1; o_ovr = accumulated ovr OR this overflow condition.
REQ-027 SHALL, in DONE, hold o_valid, o_sum, o_ovr and o_count stable until i_ready = 1, then move to IDLE on that same edge with o_valid = 0 on the next cycle.
REQ-028 SHALL ignore i_valid in DONE; there is no overlap of result hold and input accept.
REQ-029 SHALL ignore i_ready in IDLE and ACC.

Reset
REQ-030 SHALL, while i_rst_n = 0, immediately force the state to IDLE and set acc, count, ovr, o_sum, o_ovr and o_count to 0, with o_valid = 0; o_ready SHALL follow the IDLE state (1).
REQ-031 SHALL, on a reset during ACC or DONE, discard the partial vector; the next accepted beat starts a new vector.

Configuration
REQ-032 SHALL, with QACC_SAT_EN defined, set the o_sum magnitude to all ones (2^(N-1)-1) with the sign preserved when overflow occurs.
REQ-033 SHALL, with QACC_SAT_EN undefined, set the o_sum magnitude to the low N-1 bits of |acc| with the sign preserved when overflow occurs; o_ovr is set in both builds.

Verification (Q=15, N=32)
REQ-034 SHALL cover: single beat 0x00008000 with i_last -> next cycle o_valid=1, o_sum=0x00008000, o_count=1, o_ovr=0.
REQ-035 SHALL cover: beats 0x00008000, 0x00010000, 0x80004000 (last) -> o_sum=0x00014000 (+2.5), o_count=3.
REQ-036 SHALL cover: beats 0x00004000, 0x80004000 (last), then a single beat 0x80000000 (last) -> o_sum=0x00000000 both times, sign 0.
REQ-037 SHALL cover: beats 0x7FFFFFFF, 0x7FFFFFFF (last) -> o_ovr=1; o_sum=0x7FFFFFFF with QACC_SAT_EN, 0x7FFFFFFE without it; a separate vector with i_ovr=1 on its middle beat -> o_ovr=1.
REQ-038 SHALL cover: DONE with i_ready held 0 for 5 cycles while i_valid=1 -> o_ready=0, outputs stable, no beat accepted; i_ready=1 -> IDLE next cycle.
REQ-039 SHALL cover: i_rst_n pulsed low after 2 of 4 beats -> outputs 0, then a fresh beat 0x00008000 (last) -> o_sum=0x00008000, o_count=1; also MAX_LEN beats without i_last -> DONE, o_count=MAX_LEN.
